// File: rtl/genexu_mul_div_pipe.sv
// genexu_mul_div_pipe
// RISC-V M-extension execution unit. It has a pipelined multiplier, an
// iterative radix-2 restoring divider and an in-order result FIFO.
// Admission is credit based, so a stalled consumer never causes a result
// to be dropped.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_i / req_ack_o   request handshake (accepted when both are high)
//   req_opcode_bi       0 MUL, 1 MULH, 2 MULHSU, 3 MULHU,
//                       4 DIV, 5 DIVU, 6 REM, 7 REMU
//   req_src0_bi/1_bi    rs1 / rs2 operands
//   req_tag_bi          opaque tag, returned with the result
//   resp_req_o / resp_ack_i   response handshake (FIFO head)
//   resp_wdata_bo       result
//   resp_tag_bo         tag of the result
//   busy_o              any op in flight, or results still queued
module genexu_mul_div_pipe #(
   parameter int XLEN       = 32,
   parameter int MUL_STAGES = 2,
   parameter int RESP_DEPTH = 4,
   parameter int TAG_W      = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_i,
   output logic             req_ack_o,
   input  logic [2:0]       req_opcode_bi,
   input  logic [XLEN-1:0]  req_src0_bi,
   input  logic [XLEN-1:0]  req_src1_bi,
   input  logic [TAG_W-1:0] req_tag_bi,
   output logic             resp_req_o,
   input  logic             resp_ack_i,
   output logic [XLEN-1:0]  resp_wdata_bo,
   output logic [TAG_W-1:0] resp_tag_bo,
   output logic             busy_o
);

   localparam int PTR_W  = $clog2(RESP_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int PIPE_N = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;
   localparam int INF_W  = $clog2(RESP_DEPTH + PIPE_N + 2) + 1;
   localparam int ITER_W = $clog2(XLEN);

   typedef enum logic [1:0] {DIV_IDLE, DIV_ITER, DIV_DONE} div_state_e;

   div_state_e div_state_q, div_state_d;

   logic [PIPE_N-1:0] mul_vld_q, mul_vld_d;
   logic [XLEN-1:0]   mul_data_q [PIPE_N];
   logic [XLEN-1:0]   mul_data_d [PIPE_N];
   logic [TAG_W-1:0]  mul_tag_q  [PIPE_N];
   logic [TAG_W-1:0]  mul_tag_d  [PIPE_N];

   logic [XLEN-1:0]   div_quot_q, div_quot_d;
   logic [XLEN-1:0]   div_rem_q, div_rem_d;
   logic [XLEN-1:0]   div_divisor_q, div_divisor_d;
   logic [ITER_W-1:0] div_cnt_q, div_cnt_d;
   logic              div_neg_q_q, div_neg_q_d;
   logic              div_neg_r_q, div_neg_r_d;
   logic              div_is_rem_q, div_is_rem_d;
   logic [TAG_W-1:0]  div_tag_q, div_tag_d;

   logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [XLEN-1:0]   fifo_data_q [RESP_DEPTH];
   logic [TAG_W-1:0]  fifo_tag_q  [RESP_DEPTH];

   logic              is_mul_op, mul_sa, mul_sb, mul_fire, div_fire;
   logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, mul_prod;
   logic [XLEN-1:0]   mul_res;
   logic              mul_out_vld;
   logic [XLEN-1:0]   mul_out_data;
   logic [TAG_W-1:0]  mul_out_tag;
   logic              div_signed, a_neg, b_neg, div_zero, div_ovf;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic [XLEN:0]     div_shift, div_diff;
   logic              div_out_vld;
   logic [XLEN-1:0]   div_out_data, q_fin, r_fin;
   logic [CNT_W-1:0]  fifo_cnt;
   logic              fifo_empty, fifo_full, fifo_push, fifo_pop;
   logic [XLEN-1:0]   push_data;
   logic [TAG_W-1:0]  push_tag;
   logic [INF_W-1:0]  inflight;
   logic              mul_pipe_empty, div_idle;

   // Request decode and operand conditioning shared by both units.
   // Divider magnitudes are taken here so that the iteration itself is
   // always unsigned; the result signs are recorded separately.
   always_comb begin
      is_mul_op  = ~req_opcode_bi[2];
      mul_sa     = (req_opcode_bi == 3'd1) || (req_opcode_bi == 3'd2);
      mul_sb     = (req_opcode_bi == 3'd1);
      div_signed = req_opcode_bi[2] & ~req_opcode_bi[0];
      a_neg      = div_signed & req_src0_bi[XLEN-1];
      b_neg      = div_signed & req_src1_bi[XLEN-1];
      a_mag      = a_neg ? -req_src0_bi : req_src0_bi;
      b_mag      = b_neg ? -req_src1_bi : req_src1_bi;
      div_zero   = (req_src1_bi == '0);
      div_ovf    = div_signed && (req_src0_bi == {1'b1, {(XLEN-1){1'b0}}})
                   && (req_src1_bi == '1);
      mul_a_ext  = {{XLEN{mul_sa & req_src0_bi[XLEN-1]}}, req_src0_bi};
      mul_b_ext  = {{XLEN{mul_sb & req_src1_bi[XLEN-1]}}, req_src1_bi};
      mul_prod   = mul_a_ext * mul_b_ext;
      mul_res    = (req_opcode_bi == 3'd0) ? mul_prod[XLEN-1:0]
                                           : mul_prod[2*XLEN-1:XLEN];
   end

   // Credit accounting. Everything that will eventually occupy a FIFO slot
   // counts against the FIFO depth. A pop in this cycle is deliberately
   // ignored, so credit returns one cycle after the pop.
   // Ordering rules: a MUL may overtake nothing (divider must be idle) and
   // a DIV must wait for the multiplier pipe to drain.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < PIPE_N; i++) begin
         inflight = inflight + INF_W'(mul_vld_q[i]);
      end
      inflight       = inflight + INF_W'(!div_idle) + INF_W'(fifo_cnt);
      mul_pipe_empty = (mul_vld_q == '0);
      div_idle       = (div_state_q == DIV_IDLE);
      req_ack_o      = !rst_i && (inflight < INF_W'(RESP_DEPTH)) && div_idle
                       && (is_mul_op || mul_pipe_empty);
      mul_fire       = req_i && req_ack_o && is_mul_op;
      div_fire       = req_i && req_ack_o && !is_mul_op;
   end

   // Multiplier pipe. The product is formed at the input and carried down
   // MUL_STAGES-1 registers; the FIFO write acts as the final stage.
   always_comb begin
      mul_vld_d[0]  = (MUL_STAGES > 1) ? mul_fire : 1'b0;
      mul_data_d[0] = mul_res;
      mul_tag_d[0]  = req_tag_bi;
      for (int i = 1; i < PIPE_N; i++) begin
         mul_vld_d[i]  = mul_vld_q[i-1];
         mul_data_d[i] = mul_data_q[i-1];
         mul_tag_d[i]  = mul_tag_q[i-1];
      end
   end

   // With a single stage the product goes straight into the FIFO in the
   // accept cycle; otherwise it leaves from the last pipe register.
   generate
      if (MUL_STAGES == 1) begin : g_mul_comb
         assign mul_out_vld  = mul_fire;
         assign mul_out_data = mul_res;
         assign mul_out_tag  = req_tag_bi;
      end else begin : g_mul_reg
         assign mul_out_vld  = mul_vld_q[PIPE_N-1];
         assign mul_out_data = mul_data_q[PIPE_N-1];
         assign mul_out_tag  = mul_tag_q[PIPE_N-1];
      end
   endgenerate

   // Divider next-state logic. Divide-by-zero and signed overflow have
   // fixed answers and skip the iteration entirely.
   always_comb begin
      div_state_d = div_state_q;
      case (div_state_q)
         DIV_IDLE: if (div_fire) div_state_d = (div_zero || div_ovf) ? DIV_DONE : DIV_ITER;
         DIV_ITER: if (div_cnt_q == '0) div_state_d = DIV_DONE;
         DIV_DONE: div_state_d = DIV_IDLE;
         default:  div_state_d = DIV_IDLE;
      endcase
   end

   // Divider datapath. quot holds the remaining dividend bits on the left
   // and collects quotient bits on the right, one restoring step per cycle.
   // Special cases preload the final quotient/remainder with signs off.
   always_comb begin
      div_quot_d    = div_quot_q;
      div_rem_d     = div_rem_q;
      div_divisor_d = div_divisor_q;
      div_cnt_d     = div_cnt_q;
      div_neg_q_d   = div_neg_q_q;
      div_neg_r_d   = div_neg_r_q;
      div_is_rem_d  = div_is_rem_q;
      div_tag_d     = div_tag_q;
      div_shift     = {div_rem_q, div_quot_q[XLEN-1]};
      div_diff      = div_shift - {1'b0, div_divisor_q};
      if (div_state_q == DIV_IDLE && div_fire) begin
         div_tag_d     = req_tag_bi;
         div_is_rem_d  = req_opcode_bi[1];
         div_cnt_d     = ITER_W'(XLEN - 1);
         div_divisor_d = b_mag;
         if (div_zero) begin
            div_quot_d  = '1;
            div_rem_d   = req_src0_bi;
            div_neg_q_d = 1'b0;
            div_neg_r_d = 1'b0;
         end else if (div_ovf) begin
            div_quot_d  = req_src0_bi;
            div_rem_d   = '0;
            div_neg_q_d = 1'b0;
            div_neg_r_d = 1'b0;
         end else begin
            div_quot_d  = a_mag;
            div_rem_d   = '0;
            div_neg_q_d = a_neg ^ b_neg;
            div_neg_r_d = a_neg;
         end
      end else if (div_state_q == DIV_ITER) begin
         div_cnt_d = div_cnt_q - 1'b1;
         if (!div_diff[XLEN]) begin
            div_rem_d  = div_diff[XLEN-1:0];
            div_quot_d = {div_quot_q[XLEN-2:0], 1'b1};
         end else begin
            div_rem_d  = div_shift[XLEN-1:0];
            div_quot_d = {div_quot_q[XLEN-2:0], 1'b0};
         end
      end
   end

   // Divider output: restore signs and pick quotient or remainder.
   always_comb begin
      div_out_vld  = (div_state_q == DIV_DONE);
      q_fin        = div_neg_q_q ? -div_quot_q : div_quot_q;
      r_fin        = div_neg_r_q ? -div_rem_q : div_rem_q;
      div_out_data = div_is_rem_q ? r_fin : q_fin;
   end

   // Result FIFO control. The ordering rules guarantee the multiplier and
   // divider never write in the same cycle, so a simple mux is enough.
   always_comb begin
      fifo_cnt   = wr_ptr_q - rd_ptr_q;
      fifo_empty = (fifo_cnt == '0);
      fifo_full  = (fifo_cnt == CNT_W'(RESP_DEPTH));
      fifo_push  = mul_out_vld || div_out_vld;
      fifo_pop   = resp_ack_i && !fifo_empty;
      push_data  = mul_out_vld ? mul_out_data : div_out_data;
      push_tag   = mul_out_vld ? mul_out_tag : div_out_tag_w();
      wr_ptr_d   = wr_ptr_q + CNT_W'(fifo_push);
      rd_ptr_d   = rd_ptr_q + CNT_W'(fifo_pop);
   end

   function automatic logic [TAG_W-1:0] div_out_tag_w();
      return div_tag_q;
   endfunction

   assign resp_req_o    = !fifo_empty;
   assign resp_wdata_bo = fifo_data_q[rd_ptr_q[PTR_W-1:0]];
   assign resp_tag_bo   = fifo_tag_q[rd_ptr_q[PTR_W-1:0]];
   assign busy_o        = (mul_vld_q != '0) || !div_idle || !fifo_empty;

   // State registers. Reset drops every in-flight op and empties the FIFO.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         div_state_q   <= DIV_IDLE;
         mul_vld_q     <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         div_quot_q    <= '0;
         div_rem_q     <= '0;
         div_divisor_q <= '0;
         div_cnt_q     <= '0;
         div_neg_q_q   <= 1'b0;
         div_neg_r_q   <= 1'b0;
         div_is_rem_q  <= 1'b0;
         div_tag_q     <= '0;
         for (int i = 0; i < PIPE_N; i++) begin
            mul_data_q[i] <= '0;
            mul_tag_q[i]  <= '0;
         end
      end else begin
         div_state_q   <= div_state_d;
         mul_vld_q     <= mul_vld_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         div_quot_q    <= div_quot_d;
         div_rem_q     <= div_rem_d;
         div_divisor_q <= div_divisor_d;
         div_cnt_q     <= div_cnt_d;
         div_neg_q_q   <= div_neg_q_d;
         div_neg_r_q   <= div_neg_r_d;
         div_is_rem_q  <= div_is_rem_d;
         div_tag_q     <= div_tag_d;
         for (int i = 0; i < PIPE_N; i++) begin
            mul_data_q[i] <= mul_data_d[i];
            mul_tag_q[i]  <= mul_tag_d[i];
         end
      end
   end

   // FIFO storage needs no reset; validity comes from the pointers.
   // Credit must make a push into a full FIFO without a pop impossible.
   always_ff @(posedge clk_i) begin
      if (!rst_i && fifo_push) begin
         fifo_data_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
         fifo_tag_q[wr_ptr_q[PTR_W-1:0]]  <= push_tag;
      end
      if (!rst_i) begin
         a_fifo_no_overflow: assert (!(fifo_push && fifo_full && !fifo_pop));
      end
   end

endmodule

// File: tb/tb_genexu_mul_div_pipe.sv
module tb_genexu_mul_div_pipe;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_i;
   logic        req_ack_o;
   logic [2:0]  req_opcode_bi;
   logic [31:0] req_src0_bi;
   logic [31:0] req_src1_bi;
   logic [3:0]  req_tag_bi;
   logic        resp_req_o;
   logic        resp_ack_i;
   logic [31:0] resp_wdata_bo;
   logic [3:0]  resp_tag_bo;
   logic        busy_o;

   int n_compared   = 0;
   int n_mismatched = 0;

   localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
   localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;
   localparam int BUDGET = 100;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  tag;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   genexu_mul_div_pipe #(
      .XLEN(32), .MUL_STAGES(2), .RESP_DEPTH(4), .TAG_W(4)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .req_ack_o(req_ack_o),
      .req_opcode_bi(req_opcode_bi), .req_src0_bi(req_src0_bi),
      .req_src1_bi(req_src1_bi), .req_tag_bi(req_tag_bi),
      .resp_req_o(resp_req_o), .resp_ack_i(resp_ack_i),
      .resp_wdata_bo(resp_wdata_bo), .resp_tag_bo(resp_tag_bo), .busy_o(busy_o)
   );

   // Free-running clock, period 10.
   always #5 clk_i = ~clk_i;

   // Safety net so a stuck design can never hang the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic addVec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, input logic [31:0] exp, input int lat);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.tag = tag; v.exp = exp; v.lat = lat;
      vecs.push_back(v);
   endtask

   // Present one request at a negedge and hold it until acked; returns
   // just after the accepting posedge with req_i dropped.
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] tag);
      bit ok;
      ok = 1'b0;
      @(negedge clk_i);
      req_i = 1'b1; req_opcode_bi = op; req_src0_bi = a; req_src1_bi = b; req_tag_bi = tag;
      for (int i = 0; i < BUDGET; i++) begin
         #1;
         if (req_ack_o) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk_i);
      end
      if (ok) begin
         @(posedge clk_i);
         #1;
      end else begin
         checkOutput("ack_timeout", 64'(ok), 64'd1);
      end
      req_i = 1'b0;
   endtask

   // Count negedges after the accept edge until a response is visible.
   task automatic waitResp(output int k, output logic [31:0] data, output logic [3:0] tag);
      k = BUDGET + 1; data = '0; tag = '0;
      for (int i = 1; i <= BUDGET; i++) begin
         @(negedge clk_i);
         #1;
         if (resp_req_o) begin
            k = i; data = resp_wdata_bo; tag = resp_tag_bo;
            break;
         end
      end
   endtask

   initial begin
      int          k, k_div, k_ack, stale;
      logic [31:0] d, d_div;
      logic [3:0]  t, t_div;

      rst_i = 1'b1; req_i = 1'b1; resp_ack_i = 1'b0;
      req_opcode_bi = OP_MUL; req_src0_bi = 32'd1; req_src1_bi = 32'd1; req_tag_bi = 4'd0;

      addVec(OP_MUL,    32'd7,        32'hFFFFFFFD, 4'd5,  32'hFFFFFFEB, 2);
      addVec(OP_MULH,   32'd7,        32'hFFFFFFFD, 4'd1,  32'hFFFFFFFF, 2);
      addVec(OP_MULHU,  32'd7,        32'hFFFFFFFD, 4'd2,  32'h00000006, 2);
      addVec(OP_MULHSU, 32'hFFFFFFFD, 32'd7,        4'd3,  32'hFFFFFFFF, 2);
      addVec(OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 4'd4,  32'h00000000, 2);
      addVec(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd6,  32'hFFFFFFFF, 2);
      addVec(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 4'd7,  32'hFFFFFFFE, 2);
      addVec(OP_MUL,    32'h12345678, 32'h10,       4'd8,  32'h23456780, 2);
      addVec(OP_DIV,    32'hFFFFFFEC, 32'd3,        4'd9,  32'hFFFFFFFA, 34);
      addVec(OP_REM,    32'hFFFFFFEC, 32'd3,        4'd10, 32'hFFFFFFFE, 34);
      addVec(OP_DIVU,   32'd100,      32'd7,        4'd11, 32'd14,       34);
      addVec(OP_REMU,   32'd100,      32'd7,        4'd12, 32'd2,        34);
      addVec(OP_DIV,    32'd20,       32'hFFFFFFFD, 4'd13, 32'hFFFFFFFA, 34);
      addVec(OP_REM,    32'd20,       32'hFFFFFFFD, 4'd14, 32'd2,        34);
      addVec(OP_DIVU,   32'd5,        32'd0,        4'd15, 32'hFFFFFFFF, 2);
      addVec(OP_REM,    32'd5,        32'd0,        4'd0,  32'd5,        2);
      addVec(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 4'd1,  32'h80000000, 2);
      addVec(OP_REM,    32'h80000000, 32'hFFFFFFFF, 4'd2,  32'd0,        2);
      addVec(OP_DIVU,   32'h80000000, 32'hFFFFFFFF, 4'd3,  32'd0,        34);
      addVec(OP_REMU,   32'h80000000, 32'hFFFFFFFF, 4'd4,  32'h80000000, 34);
      addVec(OP_DIV,    32'd5,        32'd0,        4'd5,  32'hFFFFFFFF, 2);
      addVec(OP_REMU,   32'hFFFFFFFF, 32'd0,        4'd6,  32'hFFFFFFFF, 2);

      // Reset state, with a request pending that must not be acked.
      repeat (2) @(negedge clk_i);
      #1;
      checkOutput("reset_ack", 64'(req_ack_o), 64'd0);
      checkOutput("reset_resp_req", 64'(resp_req_o), 64'd0);
      checkOutput("reset_busy", 64'(busy_o), 64'd0);
      @(negedge clk_i);
      rst_i = 1'b0; req_i = 1'b0;

      // Single ops through the vector table.
      resp_ack_i = 1'b1;
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
         waitResp(k, d, t);
         checkOutput($sformatf("v%0d_data", i), 64'(d), 64'(vecs[i].exp));
         checkOutput($sformatf("v%0d_tag", i), 64'(t), 64'(vecs[i].tag));
         checkOutput($sformatf("v%0d_latency", i), 64'(k), 64'(vecs[i].lat));
         @(posedge clk_i);
         @(negedge clk_i);
         #1;
         checkOutput($sformatf("v%0d_busy_after", i), 64'(busy_o), 64'd0);
      end

      // Credit limit: four MULs fill the FIFO, the fifth waits for a pop.
      $display("[TB] credit sequence");
      resp_ack_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         req_i = 1'b1; req_opcode_bi = OP_MUL; req_src0_bi = 32'(i + 1);
         req_src1_bi = 32'd3; req_tag_bi = 4'(i);
         #1;
         checkOutput($sformatf("b2b_ack%0d", i), 64'(req_ack_o), 64'd1);
         @(posedge clk_i);
      end
      @(negedge clk_i);
      req_src0_bi = 32'd5; req_tag_bi = 4'd4;
      #1;
      checkOutput("fifth_ack_blocked", 64'(req_ack_o), 64'd0);
      @(posedge clk_i);
      @(negedge clk_i);
      #1;
      checkOutput("fifth_ack_blocked_full", 64'(req_ack_o), 64'd0);
      resp_ack_i = 1'b1;
      #1;
      checkOutput("pop0_tag", 64'(resp_tag_bo), 64'd0);
      checkOutput("pop0_data", 64'(resp_wdata_bo), 64'd3);
      @(posedge clk_i);
      @(negedge clk_i);
      #1;
      checkOutput("fifth_ack_after_pop", 64'(req_ack_o), 64'd1);
      checkOutput("pop1_tag", 64'(resp_tag_bo), 64'd1);
      checkOutput("pop1_data", 64'(resp_wdata_bo), 64'd6);
      @(posedge clk_i);
      #1;
      req_i = 1'b0;
      for (int j = 2; j <= 4; j++) begin
         waitResp(k, d, t);
         checkOutput($sformatf("pop%0d_tag", j), 64'(t), 64'(j));
         checkOutput($sformatf("pop%0d_data", j), 64'(d), 64'(3 * (j + 1)));
         @(posedge clk_i);
      end

      // DIV then REM: the REM is held while the DIV iterates.
      $display("[TB] div then rem sequence");
      applyStimulus(OP_DIV, 32'hFFFFFFEC, 32'd3, 4'd8);
      @(negedge clk_i);
      req_i = 1'b1; req_opcode_bi = OP_REM; req_src0_bi = 32'hFFFFFFEC;
      req_src1_bi = 32'd3; req_tag_bi = 4'd9;
      k_div = 0; k_ack = 0; d_div = '0; t_div = '0;
      for (int i = 1; i <= BUDGET; i++) begin
         #1;
         if (resp_req_o && k_div == 0) begin
            k_div = i; d_div = resp_wdata_bo; t_div = resp_tag_bo;
         end
         if (req_ack_o) begin
            k_ack = i;
            break;
         end
         @(negedge clk_i);
      end
      checkOutput("div_latency", 64'(k_div), 64'd34);
      checkOutput("div_data", 64'(d_div), 64'hFFFFFFFA);
      checkOutput("div_tag", 64'(t_div), 64'd8);
      checkOutput("rem_ack_cycle", 64'(k_ack), 64'd34);
      @(posedge clk_i);
      #1;
      req_i = 1'b0;
      waitResp(k, d, t);
      checkOutput("rem_latency", 64'(k), 64'd34);
      checkOutput("rem_data", 64'(d), 64'hFFFFFFFE);
      checkOutput("rem_tag", 64'(t), 64'd9);
      @(posedge clk_i);

      // MUL followed directly by DIV: the DIV waits for the mul pipe.
      $display("[TB] mul then div sequence");
      applyStimulus(OP_MUL, 32'd6, 32'd7, 4'd10);
      @(negedge clk_i);
      req_i = 1'b1; req_opcode_bi = OP_DIVU; req_src0_bi = 32'd100;
      req_src1_bi = 32'd7; req_tag_bi = 4'd11;
      #1;
      checkOutput("div_held_by_mul", 64'(req_ack_o), 64'd0);
      @(posedge clk_i);
      @(negedge clk_i);
      #1;
      checkOutput("div_ack_after_drain", 64'(req_ack_o), 64'd1);
      checkOutput("order_first_tag", 64'(resp_tag_bo), 64'd10);
      checkOutput("order_first_data", 64'(resp_wdata_bo), 64'd42);
      @(posedge clk_i);
      #1;
      req_i = 1'b0;
      waitResp(k, d, t);
      checkOutput("order_second_tag", 64'(t), 64'd11);
      checkOutput("order_second_data", 64'(d), 64'd14);
      checkOutput("order_second_latency", 64'(k), 64'd34);
      @(posedge clk_i);

      // Reset in the middle of a DIV with two results queued.
      $display("[TB] mid-operation reset sequence");
      resp_ack_i = 1'b0;
      applyStimulus(OP_MUL, 32'd2, 32'd3, 4'd12);
      applyStimulus(OP_MUL, 32'd4, 32'd5, 4'd13);
      applyStimulus(OP_DIV, 32'hFFFFFFEC, 32'd3, 4'd14);
      repeat (5) @(negedge clk_i);
      #1;
      checkOutput("pre_reset_busy", 64'(busy_o), 64'd1);
      checkOutput("pre_reset_resp_req", 64'(resp_req_o), 64'd1);
      rst_i = 1'b1;
      @(negedge clk_i);
      #1;
      checkOutput("post_reset_resp_req", 64'(resp_req_o), 64'd0);
      checkOutput("post_reset_busy", 64'(busy_o), 64'd0);
      rst_i = 1'b0;
      resp_ack_i = 1'b1;
      stale = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_i);
         #1;
         if (resp_req_o) stale++;
      end
      checkOutput("no_stale_responses", 64'(stale), 64'd0);
      applyStimulus(OP_MUL, 32'd3, 32'd3, 4'd15);
      waitResp(k, d, t);
      checkOutput("after_reset_data", 64'(d), 64'd9);
      checkOutput("after_reset_tag", 64'(t), 64'd15);
      checkOutput("after_reset_latency", 64'(k), 64'd2);
      @(posedge clk_i);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/genexu_mul_div_pipe.md
Name: genexu_mul_div_pipe

Overview:
- Parametrised successor of the single-slot MUL/DIV execution unit. Serves RISC-V M-extension ops for a sigma_tile-class core.
- Pipelined multiplier: one op per cycle, MUL_STAGES deep. Iterative radix-2 divider: one op in flight. Tagged requests.
- In-order result FIFO with credit-based admission, so responses are never lost when the consumer stalls.
- Sits between the core's EXU request stream and its writeback response stream.

Parameters:
- XLEN, 32, operand/result width.
- MUL_STAGES, 2, multiplier pipeline depth (>=1).
- RESP_DEPTH, 4, result FIFO entries (power of 2, >=2).
- TAG_W, 4, width of the opaque request tag returned with the result.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_i  in  1  request valid
- req_ack_o  out  1  request accepted this cycle when req_i && req_ack_o
- req_opcode_bi  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- req_src0_bi  in  XLEN  rs1 operand
- req_src1_bi  in  XLEN  rs2 operand
- req_tag_bi  in  TAG_W  tag, echoed in the response
- resp_req_o  out  1  response valid (FIFO head)
- resp_ack_i  in  1  consumer pops when resp_req_o && resp_ack_i
- resp_wdata_bo  out  XLEN  result
- resp_tag_bo  out  TAG_W  tag of result
- busy_o  out  1  any op in flight or FIFO non-empty

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: req_ack_o=0 during reset; resp_req_o=0; busy_o=0. FIFO is emptied, pipeline valids cleared, divider returns to IDLE.
- Reset mid-operation discards all in-flight ops. No response is emitted for them.
- Credit: inflight = mul pipe valid count + (div busy) + FIFO count. Admission requires inflight < RESP_DEPTH. A pop in the same cycle does not create credit until the next cycle.
- Ordering: responses leave in acceptance order.
  - MUL ops are acked only when the divider is IDLE.
  - DIV ops are acked only when the divider is IDLE and the mul pipe is empty.
  - req_ack_o is combinational from state and req_opcode_bi.
- Multiplier:
  - Signedness: MULH is signed x signed, MULHSU is signed x unsigned, MULHU is unsigned x unsigned. Full 2*XLEN product.
  - MUL returns the low XLEN bits. Other mul ops return the high XLEN bits.
  - Accepted in cycle t, written to the FIFO at the end of cycle t+MUL_STAGES-1, resp_req_o visible at t+MUL_STAGES (if the FIFO was empty).
  - Accepts back-to-back, one per cycle.
- Divider FSM: IDLE -> ITER -> DONE -> IDLE.
  - IDLE: on accept, latch magnitudes, result signs, opcode and tag.
  - Divide-by-zero and signed overflow (src0=-2^(XLEN-1), src1=-1) go directly to DONE.
  - ITER: XLEN restoring steps, one quotient bit per cycle.
  - DONE: apply signs and write the FIFO; FSM returns to IDLE the next cycle.
  - Normal latency: accepted t, resp_req_o at t+XLEN+2. Special-case latency: t+2.
  - Quotient sign = sign(src0) xor sign(src1), for signed ops only. Remainder sign = sign(src0).
  - Divide-by-zero: quotient all-ones, remainder = src0.
  - Signed overflow: quotient = src0, remainder = 0.
- FIFO:
  - Credit guarantees a write never meets a full FIFO. An internal assertion flags any overflow.
  - Simultaneous write and pop when full or empty is legal.
  - Pointer wrap uses log2(RESP_DEPTH)+1-bit pointers.
- busy_o = |mul valids | (div FSM != IDLE) | (FIFO count != 0).

Test Plan:
- MUL 7 x -3 (src1=0xFFFFFFFD), tag 5 -> one response 0xFFFFFFEB, tag 5, 2 cycles after accept. MULH with the same operands -> 0xFFFFFFFF. MULHU -> 0x00000006.
- Four back-to-back MULs (tags 0..3) with resp_ack_i held 0 -> all four acked, then req_ack_o=0 on the 5th. Raise resp_ack_i -> tags 0,1,2,3 in order, 5th acked the cycle after the first pop.
- DIV -20 / 3 then REM -20 / 3 -> 0xFFFFFFFA then 0xFFFFFFFE, each 34 cycles after its accept. The second is not acked while the first is in ITER.
- DIVU 5/0 -> 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM of that pair -> 0. Each response 2 cycles after accept.
- MUL accepted, then DIV presented the next cycle -> DIV held (req_ack_o=0) until the mul pipe drains. Response order is MUL then DIV.
- rst_i asserted during DIV ITER with 2 FIFO entries pending -> the next cycle resp_req_o=0 and busy_o=0, and no stale response appears afterwards.
